// File: rtl/fp_mult_arbiter.sv
// Shares one AXI-stream FP multiplier (blocking mode) among NUM_REQ requesters; results return in
// issue order and are routed by a tag FIFO. Define FP_MULT_ARB_STATS_EN for issue/stall counters.
module fp_mult_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int TAG_DEPTH = 16,
  parameter int DATA_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      mul_a_valid,
  input  logic                      mul_a_ready,
  output logic [DATA_W-1:0]         mul_a_data,
  output logic                      mul_b_valid,
  input  logic                      mul_b_ready,
  output logic [DATA_W-1:0]         mul_b_data,
  input  logic                      mul_res_valid,
  output logic                      mul_res_ready,
  input  logic [DATA_W-1:0]         mul_res_data,
  output logic                      tag_err
`ifdef FP_MULT_ARB_STATS_EN
  ,
  output logic [31:0]               stat_issued,
  output logic [31:0]               stat_stall
`endif
);

  localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              armed;
  logic              a_pend;
  logic              b_pend;
  logic [DATA_W-1:0] iss_a;
  logic [DATA_W-1:0] iss_b;
  logic [TAG_W-1:0]  iss_tag;
  logic [TAG_W-1:0]  rr;

  logic [TAG_W-1:0]  tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              a_hs;
  logic              b_hs;
  logic              iss_free;
  logic              push;
  logic              pop;
  logic              empty;
  logic              room;
  logic              load;
  logic [TAG_W-1:0]  grant;
  logic [TAG_W-1:0]  head_tag;

  assign a_hs     = a_pend & mul_a_ready;
  assign b_hs     = b_pend & mul_b_ready;
  assign iss_free = (~a_pend | a_hs) & (~b_pend | b_hs);
  // The tag is pushed once, on the cycle the last outstanding operand channel completes.
  assign push     = (a_pend | b_pend) & iss_free;
  assign empty    = (count == '0);
  assign head_tag = tag_mem[rd_ptr];
  assign pop      = mul_res_valid & mul_res_ready;
  assign room     = (count + CNT_W'(push)) < CNT_W'(TAG_DEPTH);
  assign load     = armed & iss_free & (|req_valid) & room;

  assign mul_a_valid = a_pend;
  assign mul_b_valid = b_pend;
  assign mul_a_data  = iss_a;
  assign mul_b_data  = iss_b;

  always_comb begin
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    grant = rr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(rr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = TAG_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = load && (grant == TAG_W'(i));
      rsp_valid[i] = mul_res_valid && !empty && (head_tag == TAG_W'(i));
    end
  end

  assign rsp_data      = mul_res_data;
  assign mul_res_ready = !empty && rsp_ready[head_tag];

  // armed keeps req_ready low while reset is asserted and for one cycle after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      a_pend  <= 1'b0;
      b_pend  <= 1'b0;
      iss_a   <= '0;
      iss_b   <= '0;
      iss_tag <= '0;
      rr      <= TAG_W'(NUM_REQ - 1);
    end else begin
      armed <= 1'b1;
      if (load) begin
        a_pend  <= 1'b1;
        b_pend  <= 1'b1;
        iss_a   <= req_a[int'(grant)*DATA_W +: DATA_W];
        iss_b   <= req_b[int'(grant)*DATA_W +: DATA_W];
        iss_tag <= grant;
        rr      <= grant;
      end else begin
        if (a_hs) a_pend <= 1'b0;
        if (b_hs) b_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= iss_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tag_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (mul_res_valid && empty) tag_err <= 1'b1;
    end
  end

`ifdef FP_MULT_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (push) stat_issued <= stat_issued + 32'd1;
      if ((|req_valid) && !load) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Directed bench for fp_mult_arbiter with a latency-8 blocking-mode multiplier model.
module tb_fp_mult_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic                      mul_a_valid, mul_a_ready;
  logic [DATA_W-1:0]         mul_a_data;
  logic                      mul_b_valid, mul_b_ready;
  logic [DATA_W-1:0]         mul_b_data;
  logic                      mul_res_valid, mul_res_ready;
  logic [DATA_W-1:0]         mul_res_data;
  logic                      tag_err;
`ifdef FP_MULT_ARB_STATS_EN
  logic [31:0]               stat_issued, stat_stall;
`endif

  int errors = 0;
  int checks = 0;

  fp_mult_arbiter #(.NUM_REQ(NUM_REQ), .TAG_DEPTH(16), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mul_a_valid(mul_a_valid), .mul_a_ready(mul_a_ready), .mul_a_data(mul_a_data),
    .mul_b_valid(mul_b_valid), .mul_b_ready(mul_b_ready), .mul_b_data(mul_b_data),
    .mul_res_valid(mul_res_valid), .mul_res_ready(mul_res_ready), .mul_res_data(mul_res_data),
    .tag_err(tag_err)
`ifdef FP_MULT_ARB_STATS_EN
    , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: single-precision product of normal numbers, truncated.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic        s;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'b0};
    p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    if (p[47]) begin
      e = e + 10'd1;
      return {s, e[7:0], p[46:24]};
    end
    return {s, e[7:0], p[45:23]};
  endfunction

  logic        a_rdy_en, b_rdy_en, inj;
  logic        a_held = 1'b0, b_held = 1'b0;
  logic [31:0] a_hold = '0, b_hold = '0;
  logic        m_valid = 1'b0;
  logic [31:0] m_data = '0;
  logic [31:0] pipe_data [$];
  int          pipe_time [$];

  assign mul_a_ready   = a_rdy_en && !a_held;
  assign mul_b_ready   = b_rdy_en && !b_held;
  assign mul_res_valid = m_valid | inj;
  assign mul_res_data  = m_data;

  always @(posedge clk) begin : mdl
    logic        ah, bh;
    logic [31:0] av, bv;
    if (!rst_n) begin
      pipe_data.delete();
      pipe_time.delete();
      a_held  <= 1'b0;
      b_held  <= 1'b0;
      m_valid <= 1'b0;
    end else begin
      ah = a_held; bh = b_held; av = a_hold; bv = b_hold;
      if (mul_a_valid && mul_a_ready) begin ah = 1'b1; av = mul_a_data; end
      if (mul_b_valid && mul_b_ready) begin bh = 1'b1; bv = mul_b_data; end
      if (ah && bh) begin
        pipe_data.push_back(fmul(av, bv));
        pipe_time.push_back(cyc + 8);
        ah = 1'b0; bh = 1'b0;
      end
      a_held <= ah; b_held <= bh; a_hold <= av; b_hold <= bv;
      if (!m_valid || mul_res_ready) begin
        if (pipe_data.size() > 0 && pipe_time[0] <= cyc) begin
          m_valid <= 1'b1;
          m_data  <= pipe_data.pop_front();
          void'(pipe_time.pop_front());
        end else begin
          m_valid <= 1'b0;
        end
      end
    end
  end

  // Grant and response logs
  int          g_idx [$];
  int          g_cyc [$];
  int          r_idx [$];
  logic [31:0] r_data [$];

  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin g_idx.push_back(i); g_cyc.push_back(cyc); end
        if (rsp_valid[i] && rsp_ready[i]) begin r_idx.push_back(i); r_data.push_back(rsp_data); end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic drive_one(input int idx, input logic [31:0] a, input logic [31:0] b, output bit ok);
    int n0;
    n0 = g_idx.size();
    ok = 1'b0;
    @(negedge clk);
    req_a[idx*DATA_W +: DATA_W] = a;
    req_b[idx*DATA_W +: DATA_W] = b;
    req_valid[idx] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (g_idx.size() > n0) begin ok = 1'b1; break; end
    end
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (r_idx.size() >= target) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'hF; rsp_ready = 4'hF; req_a = '0; req_b = '0;
    a_rdy_en = 1'b1; b_rdy_en = 1'b1; inj = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
    checks++; if ({mul_a_valid, mul_b_valid} !== 2'b00) begin errors++; $display("FAIL reset_mul_valid got=%b want=00", {mul_a_valid, mul_b_valid}); end
    checks++; if (rsp_valid !== 4'b0 || mul_res_ready !== 1'b0) begin errors++; $display("FAIL reset_rsp got=%b/%b want=0000/0", rsp_valid, mul_res_ready); end
    checks++; if (tag_err !== 1'b0) begin errors++; $display("FAIL reset_tag_err got=%b want=0", tag_err); end
    req_valid = 4'h0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 4'b0 || mul_a_valid !== 1'b0) begin errors++; $display("FAIL idle_after_reset got=%b/%b want=0000/0", req_ready, mul_a_valid); end
  endtask

  task automatic test_single();
    bit ok;
    int r0;
    r0 = r_idx.size();
    drive_one(0, 32'h40000000, 32'h40400000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_grant timeout got=0 want=1"); end
    checks++; if (mul_a_valid !== 1'b1 || mul_b_valid !== 1'b1 || mul_a_data !== 32'h40000000 || mul_b_data !== 32'h40400000) begin
      errors++; $display("FAIL single_issue got=%b%b %h %h want=11 40000000 40400000", mul_a_valid, mul_b_valid, mul_a_data, mul_b_data);
    end
    wait_rsp(r0 + 1, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_rsp timeout got=%0d want=1", r_idx.size() - r0); end
    else begin
      checks++; if (r_idx[r0] !== 0 || r_data[r0] !== 32'h40C00000) begin errors++; $display("FAIL single_rsp got=%0d %h want=0 40c00000", r_idx[r0], r_data[r0]); end
    end
    repeat (15) @(negedge clk);
    checks++; if (r_idx.size() - r0 !== 1) begin errors++; $display("FAIL single_count got=%0d want=1", r_idx.size() - r0); end
    checks++; if (mul_res_ready !== 1'b0) begin errors++; $display("FAIL single_fifo_empty mul_res_ready got=%b want=0", mul_res_ready); end
`ifdef FP_MULT_ARB_STATS_EN
    checks++; if (stat_issued !== 32'd1) begin errors++; $display("FAIL stat_issued got=%0d want=1", stat_issued); end
`endif
  endtask

  task automatic test_round_robin();
    int exp_g [6] = '{0, 1, 2, 3, 0, 1};
    logic [31:0] exp_d [4] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};
    int g0, r0;
    bit ok;
    do_reset();
    g0 = g_idx.size(); r0 = r_idx.size();
    req_a = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    req_b = {4{32'h40000000}};
    req_valid = 4'hF;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (g_idx.size() - g0 >= 6) break;
    end
    req_valid = 4'h0;
    checks++; if (g_idx.size() - g0 !== 6) begin errors++; $display("FAIL rr_grant_count got=%0d want=6", g_idx.size() - g0); end
    else begin
      for (int k = 0; k < 6; k++) begin
        checks++; if (g_idx[g0+k] !== exp_g[k] || g_cyc[g0+k] !== g_cyc[g0] + k) begin
          errors++; $display("FAIL rr_grant[%0d] got=%0d@%0d want=%0d@%0d", k, g_idx[g0+k], g_cyc[g0+k], exp_g[k], g_cyc[g0] + k);
        end
      end
    end
    wait_rsp(r0 + 6, 80, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_rsp timeout got=%0d want=6", r_idx.size() - r0); end
    else begin
      for (int k = 0; k < 6; k++) begin
        checks++; if (r_idx[r0+k] !== exp_g[k] || r_data[r0+k] !== exp_d[exp_g[k]]) begin
          errors++; $display("FAIL rr_rsp[%0d] got=%0d %h want=%0d %h", k, r_idx[r0+k], r_data[r0+k], exp_g[k], exp_d[exp_g[k]]);
        end
      end
    end
  endtask

  task automatic test_b_delay();
    int g0, r0;
    bit ok;
    b_rdy_en = 1'b0;
    r0 = r_idx.size();
    drive_one(1, 32'h40400000, 32'h40800000, ok);
    g0 = g_idx.size();
    checks++; if (!ok) begin errors++; $display("FAIL bdly_grant timeout got=0 want=1"); end
    req_a[2*DATA_W +: DATA_W] = 32'h40A00000;
    req_b[2*DATA_W +: DATA_W] = 32'h40000000;
    req_valid[2] = 1'b1;
    @(negedge clk);
    checks++; if ({mul_a_valid, mul_b_valid} !== 2'b01) begin errors++; $display("FAIL bdly_a_first got=%b want=01", {mul_a_valid, mul_b_valid}); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL bdly_no_grant got=%b want=0000", req_ready); end
    repeat (2) @(negedge clk);
    checks++; if (g_idx.size() !== g0 || mul_b_valid !== 1'b1) begin errors++; $display("FAIL bdly_stalled grants=%0d b=%b want=%0d 1", g_idx.size(), mul_b_valid, g0); end
    b_rdy_en = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bdly_free_grant got=%b want=0100", req_ready); end
    @(negedge clk);
    req_valid[2] = 1'b0;
    wait_rsp(r0 + 2, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bdly_rsp timeout got=%0d want=2", r_idx.size() - r0); end
    else begin
      checks++; if (r_idx[r0] !== 1 || r_data[r0] !== 32'h41400000 || r_idx[r0+1] !== 2 || r_data[r0+1] !== 32'h41200000) begin
        errors++; $display("FAIL bdly_rsp got=%0d %h %0d %h want=1 41400000 2 41200000", r_idx[r0], r_data[r0], r_idx[r0+1], r_data[r0+1]);
      end
    end
  endtask

  task automatic test_backpressure();
    int g0, r0, e_idx;
    logic [31:0] e_dat;
    bit ok;
    g0 = g_idx.size(); r0 = r_idx.size();
    rsp_ready = 4'b1011;
    drive_one(2, 32'h40000000, 32'h40000000, ok);
    req_a[0 +: DATA_W] = 32'h3F800000;      req_b[0 +: DATA_W] = 32'h40400000;
    req_a[DATA_W +: DATA_W] = 32'h40000000; req_b[DATA_W +: DATA_W] = 32'h40200000;
    req_valid[1:0] = 2'b11;
    repeat (45) @(negedge clk);
    checks++; if (g_idx.size() - g0 !== 16) begin errors++; $display("FAIL bp_inflight got=%0d want=16", g_idx.size() - g0); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL bp_full_req_ready got=%b want=0000", req_ready); end
    checks++; if (rsp_valid !== 4'b0100 || mul_res_ready !== 1'b0) begin errors++; $display("FAIL bp_head_stall got=%b/%b want=0100/0", rsp_valid, mul_res_ready); end
    checks++; if (r_idx.size() !== r0) begin errors++; $display("FAIL bp_no_rsp got=%0d want=0", r_idx.size() - r0); end
    req_valid = 4'h0;
    rsp_ready = 4'hF;
    wait_rsp(r0 + 16, 120, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_drain timeout got=%0d want=16", r_idx.size() - r0); end
    else begin
      for (int k = 0; k < 16; k++) begin
        e_idx = (k == 0) ? 2 : ((k % 2 == 1) ? 0 : 1);
        e_dat = (e_idx == 2) ? 32'h40800000 : ((e_idx == 0) ? 32'h40400000 : 32'h40A00000);
        checks++; if (r_idx[r0+k] !== e_idx || r_data[r0+k] !== e_dat) begin
          errors++; $display("FAIL bp_drain[%0d] got=%0d %h want=%0d %h", k, r_idx[r0+k], r_data[r0+k], e_idx, e_dat);
        end
      end
    end
  endtask

  task automatic test_tag_err();
    do_reset();
    inj = 1'b1;
    #1;
    checks++; if (mul_res_ready !== 1'b0 || rsp_valid !== 4'b0) begin errors++; $display("FAIL tagerr_ready got=%b/%b want=0/0000", mul_res_ready, rsp_valid); end
    @(negedge clk);
    checks++; if (tag_err !== 1'b1) begin errors++; $display("FAIL tagerr_set got=%b want=1", tag_err); end
    inj = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (tag_err !== 1'b1) begin errors++; $display("FAIL tagerr_sticky got=%b want=1", tag_err); end
  endtask

  task automatic test_reset_midop();
    int g0, r0;
    bit ok;
    g0 = g_idx.size();
    rsp_ready = 4'h0;
    req_a = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    req_b = {4{32'h40000000}};
    req_valid = 4'hF;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (g_idx.size() - g0 >= 5) break;
    end
    req_valid = 4'h0;
    checks++; if (g_idx.size() - g0 !== 5) begin errors++; $display("FAIL midop_issued got=%0d want=5", g_idx.size() - g0); end
    #2;
    rst_n = 1'b0;
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b0 || mul_a_valid !== 1'b0 || mul_b_valid !== 1'b0) begin
      errors++; $display("FAIL midop_reset_issue got=%b %b%b want=0000 00", req_ready, mul_a_valid, mul_b_valid);
    end
    checks++; if (rsp_valid !== 4'b0 || mul_res_ready !== 1'b0 || tag_err !== 1'b0) begin
      errors++; $display("FAIL midop_reset_rsp got=%b %b %b want=0000 0 0", rsp_valid, mul_res_ready, tag_err);
    end
`ifdef FP_MULT_ARB_STATS_EN
    checks++; if (stat_issued !== 32'd0 || stat_stall !== 32'd0) begin errors++; $display("FAIL midop_stats got=%0d %0d want=0 0", stat_issued, stat_stall); end
`endif
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL midop_hold_ready got=%b want=0000", req_ready); end
    req_valid = 4'h0;
    rst_n = 1'b1;
    rsp_ready = 4'hF;
    r0 = r_idx.size();
    repeat (20) @(negedge clk);
    checks++; if (r_idx.size() !== r0 || tag_err !== 1'b0) begin errors++; $display("FAIL midop_discard got=%0d %b want=0 0", r_idx.size() - r0, tag_err); end
    drive_one(3, 32'h40400000, 32'h40400000, ok);
    wait_rsp(r0 + 1, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midop_fresh timeout got=0 want=1"); end
    else begin
      checks++; if (r_idx[r0] !== 3 || r_data[r0] !== 32'h41100000) begin errors++; $display("FAIL midop_fresh got=%0d %h want=3 41100000", r_idx[r0], r_data[r0]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_b_delay();
    test_backpressure();
    test_tag_err();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_mult_arbiter.md
Name: fp_mult_arbiter

Overview:
Time-shares one AXI-stream floating-point multiplier (multiplier_floating_point IP, blocking mode) among NUM_REQ requesters, such as the four products in the contrast comparator. Each operand pair is tagged with its requester ID and the tag is held in a FIFO. Results come back in issue order and are routed to the owning requester. It sits between the SSIM comparator stages and a single shared multiplier instance to save DSP slices.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TAG_DEPTH, 16, max in-flight operations; power of 2, at least multiplier latency + 2
DATA_W, 32, operand/result width (IEEE-754 single)

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous assert, active-low
req_valid  in  NUM_REQ  per-requester operand pair valid
req_ready  out  NUM_REQ  per-requester accept
req_a  in  NUM_REQ*DATA_W  operand A, requester i at [i*DATA_W +: DATA_W]
req_b  in  NUM_REQ*DATA_W  operand B, same packing
rsp_valid  out  NUM_REQ  result valid, one-hot or zero
rsp_ready  in  NUM_REQ  per-requester result accept
rsp_data  out  DATA_W  shared result bus
mul_a_valid / mul_a_ready / mul_a_data  out/in/out  1/1/DATA_W  multiplier s_axis_a
mul_b_valid / mul_b_ready / mul_b_data  out/in/out  1/1/DATA_W  multiplier s_axis_b
mul_res_valid / mul_res_ready / mul_res_data  in/out/in  1/1/DATA_W  multiplier m_axis_result
tag_err  out  1  sticky: a result arrived while the tag FIFO was empty

Behaviour:
- Reset values (async, rst_n=0): req_ready=0, mul_a_valid=0, mul_b_valid=0, tag FIFO empty, rr pointer=NUM_REQ-1, tag_err=0. Consequently rsp_valid=0 and mul_res_ready=0.
- Issue register (ISS): holds a, b, tag, and flags a_pend and b_pend.
  - mul_a_valid=a_pend; mul_b_valid=b_pend.
  - A handshake on a clears a_pend; a handshake on b clears b_pend. They may complete in different cycles.
- ISS is "free" when a_pend=b_pend=0, or when every pending channel handshakes this cycle.
- Load condition: free && any req_valid && tag FIFO count + pending push < TAG_DEPTH.
  - Grant goes to the first valid requester, searching round-robin from rr+1 modulo NUM_REQ.
  - req_ready is asserted only for the granted index, and only when the load condition holds.
  - On the req handshake: ISS captures the operands and tag, a_pend=b_pend=1 on the next edge, and rr is set to the grant.
  - req_ready never depends on mul_*_ready beyond the free computation; the mul valids are registered.
- Tag push: on the cycle the last pending operand handshakes, push the ISS tag. The push count is one per operation.
- Issue throughput: one operation per cycle when the multiplier always accepts. Latency from req handshake to mul valid is 1 cycle.
- Result routing, combinational from the FIFO head tag h:
  - rsp_valid[h]=mul_res_valid && !empty; all other bits 0.
  - rsp_data=mul_res_data.
  - mul_res_ready=rsp_ready[h] && !empty.
  - Pop the tag on the mul_res handshake.
- Empty FIFO with mul_res_valid=1: mul_res_ready=0 and tag_err is set (sticky until reset).
- Full FIFO: no new loads. An operation already in ISS still completes; its push is reserved, so no overflow is possible.
- Simultaneous push and pop: both take effect; count is unchanged.
- Backpressure by the head requester stalls all results (in-order). Other requesters may still issue until the FIFO fills.
- Reset mid-operation: all in-flight tags are discarded. The bench must also reset the multiplier.

Optional Feature:
FP_MULT_ARB_STATS_EN:
- Defined: adds outputs stat_issued[31:0], counting completed operation issues, and stat_stall[31:0], counting cycles with any req_valid but no load.
  - Both are wrapping counters, reset to 0.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Req0 a=0x40000000, b=0x40400000; multiplier model latency 8 -> exactly one rsp_valid[0] pulse with rsp_data=0x40C00000; FIFO empty afterward.
- All four req_valid held, rsp_ready all 1 -> grant order 0,1,2,3,0,1 on consecutive cycles; responses return tagged in the same order.
- mul_a_ready=1 with mul_b_ready delayed 3 cycles -> a_pend clears first; push occurs on the b handshake; no new grant until free.
- rsp_ready[2]=0 for 20 cycles while req2's result is at the head -> mul_res_ready=0 and no result is lost.
  - Issues continue until 16 are in flight, then req_ready=0.
  - On release, results drain in order.
- Inject mul_res_valid=1 with nothing issued -> mul_res_ready=0, tag_err=1 and held.
- rst_n pulsed low with 5 operations in flight -> all outputs at reset values immediately; after release, a fresh request completes correctly.
  - With FP_MULT_ARB_STATS_EN defined, the counters read 0 after reset.
